// File: rtl/find_first_one_pipe_pkg.sv
// Shared fp_library definitions: search-mode encoding, default priority-group
// width and a constant-foldable ceil(log2) helper for width derivation.
package fp_lib_pkg;

    localparam int FFO_GROUP_DEFAULT = 8;

    typedef enum logic {
        FFO_MSB = 1'b0,
        FFO_LSB = 1'b1
    } ffo_mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/find_first_one_pipe_if.sv
// Operand/result stream bundle for the find-first-one pipeline.
// master drives operands and consumes results; slave is the detector.
interface find_first_one_pipe_if #(
    parameter int WIDTH = 32
) ();
    localparam int POSW = fp_lib_pkg::clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_lsb;
    logic             out_valid;
    logic             out_ready;
    logic [POSW-1:0]  out_pos;
    logic             out_zero;
    logic [WIDTH-1:0] out_norm;
    logic             out_lsb;

    modport master (
        output in_valid, in_data, in_lsb, out_ready,
        input  in_ready, out_valid, out_pos, out_zero, out_norm, out_lsb
    );

    modport slave (
        input  in_valid, in_data, in_lsb, out_ready,
        output in_ready, out_valid, out_pos, out_zero, out_norm, out_lsb
    );

endinterface

// File: rtl/find_first_one_pipe_ffo_group.sv
// Combinational GROUP-bit priority encoder: flags any set bit and returns the
// index of the highest (MSB mode) or lowest (LSB mode) one within the group.
module ffo_group
    import fp_lib_pkg::*;
#(
    parameter  int GROUP = FFO_GROUP_DEFAULT,
    localparam int IW    = (GROUP > 1) ? clog2(GROUP) : 1
) (
    input  logic [GROUP-1:0] bits,
    input  logic             lsb,
    output logic             any,
    output logic [IW-1:0]    idx
);

    // Later loop iterations override earlier ones, so scan order sets priority.
    always_comb begin
        any = |bits;
        idx = '0;
        if (lsb == FFO_LSB) begin
            for (int i = GROUP - 1; i >= 0; i--) begin
                if (bits[i]) idx = IW'(i);
            end
        end else begin
            for (int i = 0; i < GROUP; i++) begin
                if (bits[i]) idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/find_first_one_pipe.sv
// Two-stage leading/trailing-one detector and normaliser.
// S1 registers per-group any/index flags, S2 registers the selected position
// and the shifted operand, which drive the result port directly.
module find_first_one_pipe
    import fp_lib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = FFO_GROUP_DEFAULT
) (
    input logic                 clk,
    input logic                 rst_n,
    find_first_one_pipe_if.slave bus
);
    localparam int POSW = clog2(WIDTH);
    localparam int IW   = (GROUP > 1) ? clog2(GROUP) : 1;
    localparam int NG   = (WIDTH + GROUP - 1) / GROUP;
    localparam int PW   = NG * GROUP;
    localparam int GW   = (NG > 1) ? clog2(NG) : 1;

    logic             s1_v;
    logic             s2_v;
    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] s1_data;
    logic             s1_lsb;
    logic [NG-1:0]    s1_any;
    logic [IW-1:0]    s1_idx [NG];
    logic [PW-1:0]    padded;
    logic [NG-1:0]    grp_any;
    logic [IW-1:0]    grp_idx [NG];
    logic [GW-1:0]    sel;
    logic             zero_c;
    logic [POSW-1:0]  pos_c;
    logic [WIDTH-1:0] norm_c;
    logic [POSW-1:0]  s2_pos;
    logic             s2_zero;
    logic [WIDTH-1:0] s2_norm;
    logic             s2_lsb;

    assign s2_load      = !s2_v || bus.out_ready;
    assign s1_load      = !s1_v || s2_load;
    assign bus.in_ready = s1_load;

    // Top group is zero-extended, so padding bits can never be selected.
    assign padded = PW'(bus.in_data);

    for (genvar g = 0; g < NG; g++) begin : g_grp
        ffo_group #(.GROUP(GROUP)) u_grp (
            .bits (padded[g*GROUP +: GROUP]),
            .lsb  (bus.in_lsb),
            .any  (grp_any[g]),
            .idx  (grp_idx[g])
        );
    end

    // Stage valids: S1 refills whenever it is empty or drains into S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
        end else if (s1_load) begin
            s1_v <= bus.in_valid;
        end
    end

    // S1 payload needs no reset; it is qualified by s1_v.
    always_ff @(posedge clk) begin
        if (s1_load && bus.in_valid) begin
            s1_data <= bus.in_data;
            s1_lsb  <= bus.in_lsb;
            s1_any  <= grp_any;
            s1_idx  <= grp_idx;
        end
    end

    // Winning group, final position and barrel shift from the S1 snapshot.
    always_comb begin
        sel = '0;
        if (s1_lsb == FFO_LSB) begin
            for (int g = NG - 1; g >= 0; g--) begin
                if (s1_any[g]) sel = GW'(g);
            end
        end else begin
            for (int g = 0; g < NG; g++) begin
                if (s1_any[g]) sel = GW'(g);
            end
        end
        zero_c = ~|s1_any;
        pos_c  = zero_c ? '0 : POSW'(int'(sel) * GROUP + int'(s1_idx[sel]));
        if (zero_c) begin
            norm_c = '0;
        end else if (s1_lsb == FFO_LSB) begin
            norm_c = s1_data >> pos_c;
        end else begin
            norm_c = s1_data << (POSW'(WIDTH - 1) - pos_c);
        end
    end

    // S2 holds the presented result; it only changes when it may be replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_pos  <= '0;
            s2_zero <= 1'b0;
            s2_norm <= '0;
            s2_lsb  <= 1'b0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_pos  <= pos_c;
                s2_zero <= zero_c;
                s2_norm <= norm_c;
                s2_lsb  <= s1_lsb;
            end
        end
    end

    assign bus.out_valid = s2_v;
    assign bus.out_pos   = s2_pos;
    assign bus.out_zero  = s2_zero;
    assign bus.out_norm  = s2_norm;
    assign bus.out_lsb   = s2_lsb;

endmodule

// File: tb/tb_find_first_one_pipe.sv
// Directed and random checks of find_first_one_pipe with a result scoreboard;
// a second WIDTH=20 instance covers a partial top priority group.
module tb_find_first_one_pipe;

    localparam int W    = 32;
    localparam int POSW = $clog2(W);

    typedef struct {
        logic [POSW-1:0] pos;
        logic            zero;
        logic [W-1:0]    norm;
        logic            lsb;
        int              cyc;
        bit              lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    find_first_one_pipe_if #(.WIDTH(W))  bus ();
    find_first_one_pipe_if #(.WIDTH(20)) bus20 ();

    find_first_one_pipe #(.WIDTH(W), .GROUP(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    find_first_one_pipe #(.WIDTH(20), .GROUP(8)) dut20 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus20)
    );

    exp_t sb[$];
    exp_t cur;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_pop = 0;
    int   n_out = 0;
    bit   acc;
    bit   lat_chk = 1'b1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] d, input logic l);
        exp_t e;
        int   p;
        p = 0;
        if (l) begin
            for (int i = W - 1; i >= 0; i--) if (d[i]) p = i;
        end else begin
            for (int i = 0; i < W; i++) if (d[i]) p = i;
        end
        e.zero = (d == '0);
        e.pos  = e.zero ? '0 : POSW'(p);
        e.norm = e.zero ? '0 : (l ? (d >> p) : (d << (W - 1 - p)));
        e.lsb  = l;
        e.cyc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    // One clock: sample handshakes just after the falling edge, then advance.
    task automatic step();
        exp_t e;
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            cur.cyc = cyc;
            cur.lat = lat_chk;
            sb.push_back(cur);
        end
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_output", bus.out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                n_pop++;
                check("pos", bus.out_pos, e.pos);
                check("zero", bus.out_zero, e.zero);
                check("norm", bus.out_norm, e.norm);
                check("lsb", bus.out_lsb, e.lsb);
                if (e.lat) check("latency", cyc - e.cyc, 2);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drive(input logic [W-1:0] d, input logic l, input logic [POSW-1:0] p,
                         input logic z, input logic [W-1:0] n);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_lsb   = l;
        cur.pos  = p;
        cur.zero = z;
        cur.norm = n;
        cur.lsb  = l;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, input logic [POSW-1:0] p,
                        input logic z, input logic [W-1:0] n);
        drive(d, l, p, z, n);
        for (int k = 0; k < 50; k++) begin
            step();
            if (acc) break;
        end
        if (!acc) check("accept_timeout", acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [W-1:0] d, input logic l);
        exp_t e;
        e = model(d, l);
        drive(d, l, e.pos, e.zero, e.norm);
    endtask

    task automatic send20(input logic [19:0] d, input logic l, input logic [4:0] p,
                          input logic z, input logic [19:0] n);
        bus20.in_valid = 1'b1;
        bus20.in_data  = d;
        bus20.in_lsb   = l;
        check("w20_in_ready", bus20.in_ready, 1'b1);
        step();
        bus20.in_valid = 1'b0;
        step();
        check("w20_out_valid", bus20.out_valid, 1'b1);
        check("w20_pos", bus20.out_pos, p);
        check("w20_zero", bus20.out_zero, z);
        check("w20_norm", bus20.out_norm, n);
    endtask

    initial begin
        logic [W-1:0] ops [5];
        exp_t         e;
        logic [W-1:0] d;
        logic         l;
        int           i;
        int           mark;
        int           nacc;

        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_lsb      = 1'b0;
        bus.out_ready   = 1'b1;
        bus20.in_valid  = 1'b0;
        bus20.in_data   = '0;
        bus20.in_lsb    = 1'b0;
        bus20.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_pos", bus.out_pos, 0);
        check("rst_out_zero", bus.out_zero, 1'b0);
        check("rst_out_norm", bus.out_norm, 0);
        check("rst_out_lsb", bus.out_lsb, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // MSB mode
        send(32'h0000_0001, 1'b0, 5'd0,  1'b0, 32'h8000_0000);
        send(32'h8000_0000, 1'b0, 5'd31, 1'b0, 32'h8000_0000);
        send(32'h0001_2345, 1'b0, 5'd16, 1'b0, 32'h91A2_8000);
        idle(3);

        // LSB mode
        send(32'h0001_2340, 1'b1, 5'd6,  1'b0, 32'h0000_048D);
        send(32'h8000_0000, 1'b1, 5'd31, 1'b0, 32'h0000_0001);
        idle(3);

        // Zero operand both modes, then recovery
        send(32'h0, 1'b0, 5'd0, 1'b1, 32'h0);
        send(32'h0, 1'b1, 5'd0, 1'b1, 32'h0);
        send(32'h10, 1'b0, 5'd4, 1'b0, 32'h8000_0000);
        send(32'h10, 1'b1, 5'd4, 1'b0, 32'h0000_0001);
        idle(3);

        // Partial top group build
        send20(20'h80000, 1'b0, 5'd19, 1'b0, 20'h80000);
        send20(20'h80000, 1'b1, 5'd19, 1'b0, 20'h00001);
        send20(20'h00300, 1'b0, 5'd9,  1'b0, 20'hC0000);
        send20(20'h00300, 1'b1, 5'd8,  1'b0, 20'h00003);
        send20(20'h00000, 1'b0, 5'd0,  1'b1, 20'h00000);

        // Back-pressure
        lat_chk = 1'b0;
        ops[0] = 32'h0000_0F00;
        ops[1] = 32'h0040_0001;
        ops[2] = 32'hA000_0000;
        ops[3] = 32'h0000_0000;
        ops[4] = 32'h0000_8080;
        bus.out_ready = 1'b0;
        i = 0;
        for (int s = 0; s < 8; s++) begin
            if (i < 5) send_rand(ops[i], i[0]);
            else bus.in_valid = 1'b0;
            step();
            if (acc) i++;
            if (s == 4) begin
                e = model(ops[0], 1'b0);
                check("bp_hold_pos_early", bus.out_pos, e.pos);
            end
        end
        e = model(ops[0], 1'b0);
        check("bp_accepted", i, 2);
        check("bp_in_ready", bus.in_ready, 1'b0);
        check("bp_out_valid", bus.out_valid, 1'b1);
        check("bp_hold_pos", bus.out_pos, e.pos);
        check("bp_hold_norm", bus.out_norm, e.norm);
        bus.out_ready = 1'b1;
        mark = n_pop;
        for (int s = 0; s < 40 && (i < 5 || sb.size() > 0); s++) begin
            if (i < 5) send_rand(ops[i], i[0]);
            else bus.in_valid = 1'b0;
            step();
            if (acc) i++;
        end
        bus.in_valid = 1'b0;
        check("bp_all_accepted", i, 5);
        check("bp_pops", n_pop - mark, 5);
        check("bp_sb_empty", sb.size(), 0);

        // Full throughput with random operands
        lat_chk = 1'b1;
        mark = n_pop;
        nacc = 0;
        for (int k = 0; k < 100; k++) begin
            d = $urandom;
            if (k % 10 == 3) d = '0;
            if (k % 10 == 7) d = 32'h1 << $urandom_range(0, 31);
            l = 1'($urandom_range(0, 1));
            send_rand(d, l);
            step();
            if (acc) nacc++;
        end
        bus.in_valid = 1'b0;
        idle(3);
        check("tp_accepted", nacc, 100);
        check("tp_pops", n_pop - mark, 100);

        // Async reset with two operands in flight
        lat_chk = 1'b0;
        bus.out_ready = 1'b0;
        send_rand(32'h0000_0100, 1'b0);
        step();
        send_rand(32'h0000_0200, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("rst_pre_out_valid", bus.out_valid, 1'b1);
        check("rst_pre_in_ready", bus.in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", bus.out_valid, 1'b0);
        check("rst_mid_out_norm", bus.out_norm, 0);
        check("rst_mid_in_ready", bus.in_ready, 1'b1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        mark = n_out;
        idle(6);
        check("rst_no_output", n_out - mark, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
